fifo_read_adapter: RTL and testbench
====================================

Name: fifo_read_adapter

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Pops words via the FIFO's rd_en/data_out port, which has a 1-cycle read latency, and re-presents them on a valid/ready stream.
- Uses a 2-entry output buffer so the stream sustains 1 word/cycle while downstream may stall at any time.
- Sits between the FIFO read port and any streaming consumer; it is the read-side counterpart of the FIFO write-side stimulus.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO's data_out width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted fifo_rd_en.
- fifo_rd_en  output  1  FIFO pop request; combinational.
- m_valid  output  1  stream word available.
- m_data  output  FIFO_WIDTH  stream word (buffer head).
- m_ready  input  1  downstream accepts m_data this cycle.
- overflow_err  output  1  sticky; a FIFO word arrived with no free buffer slot.

Behaviour:
- Reset (rst=1 at posedge):
  - occupancy=0, inflight=0, both buffer entries=0.
  - m_valid=0, m_data=0, overflow_err=0.
  - fifo_rd_en is forced 0 while rst=1.
- Occupancy FSM states: EMPTY(0), ONE(1), TWO(2).
- Per-cycle signals:
  - pop = m_valid & m_ready.
  - arrive = inflight (registered).
- Occupancy transitions:
  - arrive & !pop: +1.
  - pop & !arrive: -1.
  - both or neither: hold.
- Read request:
  - fifo_rd_en = !rst & !fifo_empty & ((occupancy + inflight - pop) < 2).
  - Combinational path from m_ready to fifo_rd_en is intentional; it provides full throughput.
- inflight <= fifo_rd_en at each posedge (cleared by rst).
- Latency: a word popped at cycle N is captured at N+1 and appears on m_data/m_valid at N+2.
- Ordering:
  - Strict FIFO order.
  - The head entry drives m_data; on pop the second entry shifts to head.
  - An arriving word goes to the first free slot after the shift.
  - Simultaneous pop+arrive in state ONE: the arriving word becomes head.
- Stability: while m_valid=1 and m_ready=0, m_data holds stable. m_valid never drops without a pop.
- m_data when m_valid=0: holds the last value; no meaning.
- Throughput: with fifo_empty=0 and m_ready=1 held, m_valid=1 every cycle from N+2 onward.
- Downstream stall: at most 2 words are buffered or in flight; fifo_rd_en deasserts. No data loss.
- FIFO empty: no request issued; state drains normally.
- Overflow: an arrival in state TWO without a simultaneous pop sets overflow_err (sticky until rst) and drops the word. This is unreachable by design; it exists for upstream protocol errors.
- Reset mid-operation: in-flight read is discarded (inflight cleared); a word on fifo_data_out in the cycle after reset is ignored. The FIFO is reset in the same cycle by the system.

Optional Feature:
- Macro: FIFO_READ_ADAPTER_STATS_EN.
- When defined, adds output word_count [31:0]:
  - Increments on every pop and wraps at 2^32-1 -> 0.
  - Reset to 0 by rst.
- Also adds output stall_count [31:0]:
  - Increments each cycle m_valid=1 & m_ready=0, with the same wrap behaviour.
  - Reset to 0 by rst.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with fifo_empty=0, m_ready=1 -> fifo_rd_en=0, m_valid=0, m_data=0, overflow_err=0 throughout.
- Streaming: FIFO model holds 0x0001..0x0008, m_ready=1 constant -> fifo_rd_en high 8 cycles, m_valid high 8 consecutive cycles starting 2 cycles after the first rd_en, m_data 0x0001..0x0008 in order.
- Backpressure: 8 words queued, m_ready=0 -> exactly 2 rd_en pulses, m_valid=1, m_data=0x0001 stable. Raise m_ready -> remaining words delivered in order, no gaps after a 1-cycle refill.
- Random m_ready (50%) over 10000 cycles with random FIFO writes -> scoreboard matches every word in order, overflow_err stays 0.
- Reset mid-stream: assert rst in the cycle after a fifo_rd_en -> next cycle m_valid=0, occupancy=0. The FIFO word 0xBEEF on fifo_data_out is not delivered.
- Overflow injection: force inflight arrival with occupancy=2, m_ready=0 -> overflow_err=1, remains 1 until rst. m_data unchanged. With STATS_EN defined, word_count equals the number of pops.

Source files
------------

// File: rtl/fifo_read_adapter.sv
// Pops a 1-cycle-latency FIFO read port and re-presents the words on a valid/ready stream through a 2-entry buffer.
// Latency: a word requested in cycle N is visible on m_data in cycle N+2. Sustains 1 word/cycle.
// Backpressure: requests stop once buffered plus in-flight words reach 2. Optional counters: FIFO_READ_ADAPTER_STATS_EN.
module fifo_read_adapter #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  overflow_err
`ifdef FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [31:0]           word_count,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic                  ovf_q, ovf_d;
  logic                  pop;
  logic                  arrive;
  logic [2:0]            committed;

  assign m_valid      = (occ_q != EMPTY);
  assign m_data       = buf0_q;
  assign overflow_err = ovf_q;
  assign pop          = m_valid & m_ready;
  assign arrive       = inflight_q;

  // Slots that will still be claimed after this cycle's pop; m_ready feeds rd_en directly for full rate.
  assign committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (committed < 3'd2);
  assign inflight_d = fifo_rd_en;

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    ovf_d  = ovf_q;
    case (occ_q)
      EMPTY: begin
        if (arrive) begin
          buf0_d = fifo_data_out;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (arrive && pop) begin
          buf0_d = fifo_data_out;
        end else if (arrive) begin
          buf1_d = fifo_data_out;
          occ_d  = TWO;
        end else if (pop) begin
          occ_d  = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (arrive) buf1_d = fifo_data_out;
          else        occ_d  = ONE;
        end else if (arrive) begin
          // No slot left: the word is dropped and the error latched.
          ovf_d = 1'b1;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  assign word_count  = word_count_q;
  assign stall_count = stall_count_q;

  always_comb begin
    word_count_d  = word_count_q + {31'd0, pop};
    stall_count_d = stall_count_q + {31'd0, (m_valid & !m_ready)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      word_count_q  <= word_count_d;
      stall_count_q <= stall_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: queue-based FIFO model, scoreboard of written words, separate stream monitor.
module tb_fifo_read_adapter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready = 1'b0;
  logic         overflow_err;
`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [31:0]  word_count;
  logic [31:0]  stall_count;
`endif

  fifo_read_adapter #(.FIFO_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .overflow_err(overflow_err)
`ifdef FIFO_READ_ADAPTER_STATS_EN
    ,
    .word_count(word_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         rd_prev = 1'b0;
  logic         last_rd = 1'b0;
  logic [W-1:0] pend_dat = '0;
  logic [W-1:0] next_w = '0;
  bit           rand_vals = 1'b0;
  bit           rdy_rand = 1'b0;
  bit           rdy_cfg = 1'b0;
  int           issued = 0;
  int           delivered = 0;
  int           stalls = 0;
  int           rd_cnt, valid_cnt, first_rd, first_v, last_v;
  logic         stall_prev = 1'b0;
  logic [W-1:0] held = '0;
  bit           found;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: all inputs change on the falling edge, FIFO read data follows a request by one cycle.
  task automatic step(input int nwr, input bit r);
    logic [W-1:0] w;
    @(negedge clk);
    rst = r;
    fifo_data_out = rd_prev ? pend_dat : W'($urandom);
    for (int i = 0; i < nwr; i++) begin
      w = rand_vals ? W'($urandom) : next_w;
      next_w = next_w + 1'b1;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty = (fifo_q.size() == 0);
    m_ready = rdy_rand ? 1'($urandom % 2) : rdy_cfg;
    #1;
    last_rd = fifo_rd_en;
    check("rd_en_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    if (r) check("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
    if (fifo_rd_en && fifo_q.size() != 0) begin
      pend_dat = fifo_q.pop_front();
      issued++;
    end
    rd_prev = fifo_rd_en;
    if (r) begin
      // The FIFO is reset alongside the adapter.
      fifo_q.delete();
      exp_q.delete();
      issued = 0;
      delivered = 0;
      stalls = 0;
    end
  endtask

  task automatic run_obs(input int n, input int first_nwr);
    rd_cnt = 0; valid_cnt = 0; first_rd = -1; first_v = -1; last_v = -1;
    for (int k = 0; k < n; k++) begin
      step((k == 0) ? first_nwr : 0, 1'b0);
      if (last_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = k;
      end
      if (m_valid) begin
        valid_cnt++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
    end
  endtask

  // Stream monitor: every handshake is matched against the scoreboard in order.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("valid_held", 32'(m_valid), 32'd1);
          check("data_held", 32'(m_data), 32'(held));
        end
        if (m_valid && m_ready) begin
          check("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
          delivered++;
        end
        if (m_valid && !m_ready) stalls++;
        check("outstanding_le2", 32'((issued - delivered) <= 2), 32'd1);
        stall_prev = m_valid && !m_ready;
        held = m_data;
      end
    end
  end

  initial begin
    // Reset with a non-empty FIFO and a ready sink.
    rdy_cfg = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(2, 1'b1);
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_overflow", 32'(overflow_err), 32'd0);
    end

    // Streaming 1..8 at full rate.
    next_w = 16'h0001;
    run_obs(14, 8);
    check("stream_rd_cnt", 32'(rd_cnt), 32'd8);
    check("stream_first_rd", 32'(first_rd), 32'd0);
    check("stream_first_valid", 32'(first_v), 32'd2);
    check("stream_valid_cnt", 32'(valid_cnt), 32'd8);
    check("stream_valid_contig", 32'(last_v - first_v + 1), 32'd8);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: sink stalled, then released.
    step(0, 1'b1);
    next_w = 16'h0001;
    rdy_cfg = 1'b0;
    run_obs(10, 8);
    check("stall_rd_cnt", 32'(rd_cnt), 32'd2);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    check("stall_m_data", 32'(m_data), 32'h0001);
    rdy_cfg = 1'b1;
    run_obs(12, 0);
    check("release_rd_cnt", 32'(rd_cnt), 32'd6);
    check("release_first_valid", 32'(first_v), 32'd0);
    check("release_valid_cnt", 32'(valid_cnt), 32'd8);
    check("release_valid_contig", 32'(last_v - first_v + 1), 32'd8);
    check("release_drained", 32'(exp_q.size()), 32'd0);

    // Random writes and random sink readiness.
    step(0, 1'b1);
    rand_vals = 1'b1;
    rdy_rand = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      step(($urandom % 64 == 0) ? 3 : (($urandom % 8 < 3) ? 1 : 0), 1'b0);
    end
`ifdef FIFO_READ_ADAPTER_STATS_EN
    check("word_count", word_count, 32'(delivered));
    check("stall_count", stall_count, 32'(stalls));
`endif
    rdy_rand = 1'b0;
    rdy_cfg = 1'b1;
    for (int k = 0; k < 4000 && exp_q.size() != 0; k++) step(0, 1'b0);
    step(0, 1'b0);
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_overflow", 32'(overflow_err), 32'd0);

    // Reset right after a read request; the in-flight word must not surface.
    step(0, 1'b1);
    rand_vals = 1'b0;
    next_w = 16'h0100;
    step(4, 1'b0);
    step(0, 1'b0);
    found = last_rd;
    for (int k = 0; k < 10 && !found; k++) begin
      step(0, 1'b0);
      found = last_rd;
    end
    check("midreset_rd_seen", 32'(found), 32'd1);
    pend_dat = 16'hBEEF;
    step(0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b0);
      check("midreset_m_valid", 32'(m_valid), 32'd0);
    end
    check("midreset_overflow", 32'(overflow_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
